// File: rtl/sprite_animator.sv
// Sprite pixel engine: hit test and ROM addressing for a positioned, optionally
// mirrored sprite, a pipeline aligned to ROM latency, and an animation-frame sequencer.
module sprite_animator #(
  parameter int SPR_W      = 64,
  parameter int SPR_H      = 96,
  parameter int NUM_FRAMES = 6,
  parameter int HOLD       = 4,
  parameter int IDX_W      = 4,
  parameter int ADDR_W     = 16,
  parameter int COORD_W    = 10,
  parameter int TRANSP_IDX = 0,
  parameter int ROM_LAT    = 1,
  localparam int FW        = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic               vga_clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  input  logic               blank,
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
  input  logic               flip,
  input  logic               frame_tick,
  input  logic               anim_start,
  input  logic               loop_mode,
  output logic [ADDR_W-1:0]  rom_address,
  input  logic [IDX_W-1:0]   rom_q,
  output logic [IDX_W-1:0]   pix_idx,
  output logic               pix_on,
  output logic [FW-1:0]      cur_frame,
  output logic               anim_done,
  output logic [1:0]         anim_state
);

  localparam int FRAME_SZ = SPR_W * SPR_H;
  localparam int HW       = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [FW-1:0]       cur_frame_q, cur_frame_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic                anim_done_q, anim_done_d;
  logic [ADDR_W-1:0]   rom_address_q, rom_address_d;
  logic [ROM_LAT:0]    hit_q, blank_q;
  logic [IDX_W-1:0]    pix_idx_q, pix_idx_d;
  logic                pix_on_q, pix_on_d;

  // Hit test in COORD_W+1 bits so a sprite hanging off the right/bottom edge clips instead of wrapping.
  logic [COORD_W:0]    x_lo, x_hi, y_lo, y_hi, dx, dy;
  logic [COORD_W-1:0]  col, row, ecol;
  logic                hit;

  always_comb begin
    dx   = {1'b0, DrawX};
    dy   = {1'b0, DrawY};
    x_lo = {1'b0, pos_x};
    y_lo = {1'b0, pos_y};
    x_hi = x_lo + (COORD_W+1)'(SPR_W);
    y_hi = y_lo + (COORD_W+1)'(SPR_H);
    hit  = (dx >= x_lo) && (dx < x_hi) && (dy >= y_lo) && (dy < y_hi);
    col  = DrawX - pos_x;
    row  = DrawY - pos_y;
    ecol = flip ? (COORD_W'(SPR_W - 1) - col) : col;
    rom_address_d = '0;
    if (hit) begin
      rom_address_d = ADDR_W'(cur_frame_q) * ADDR_W'(FRAME_SZ)
                    + ADDR_W'(row) * ADDR_W'(SPR_W) + ADDR_W'(ecol);
    end
    pix_on_d  = hit_q[ROM_LAT] & blank_q[ROM_LAT] & (rom_q != IDX_W'(TRANSP_IDX));
    pix_idx_d = pix_on_d ? rom_q : '0;
  end

  // anim_start overrides everything, including a coincident frame_tick.
  always_comb begin
    state_d     = state_q;
    cur_frame_d = cur_frame_q;
    hold_d      = hold_q;
    anim_done_d = 1'b0;
    if (anim_start) begin
      state_d     = S_PLAY;
      cur_frame_d = '0;
      hold_d      = '0;
    end else begin
      case (state_q)
        S_IDLE: cur_frame_d = '0;
        S_PLAY: begin
          if (frame_tick) begin
            if (hold_q == HW'(HOLD - 1)) begin
              hold_d = '0;
              if (cur_frame_q != FW'(NUM_FRAMES - 1)) begin
                cur_frame_d = cur_frame_q + 1'b1;
              end else if (loop_mode) begin
                cur_frame_d = '0;
              end else begin
                state_d     = S_DONE;
                anim_done_d = 1'b1;
              end
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cur_frame_q   <= '0;
      hold_q        <= '0;
      anim_done_q   <= 1'b0;
      rom_address_q <= '0;
      hit_q         <= '0;
      blank_q       <= '0;
      pix_idx_q     <= '0;
      pix_on_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_frame_q   <= cur_frame_d;
      hold_q        <= hold_d;
      anim_done_q   <= anim_done_d;
      rom_address_q <= rom_address_d;
      hit_q         <= {hit_q[ROM_LAT-1:0], hit};
      blank_q       <= {blank_q[ROM_LAT-1:0], blank};
      pix_idx_q     <= pix_idx_d;
      pix_on_q      <= pix_on_d;
    end
  end

  assign rom_address = rom_address_q;
  assign pix_idx     = pix_idx_q;
  assign pix_on      = pix_on_q;
  assign cur_frame   = cur_frame_q;
  assign anim_done   = anim_done_q;
  assign anim_state  = state_q;

endmodule

// File: tb/tb_sprite_animator.sv
// Bench for sprite_animator: directed scenarios plus randomized pixels scored
// against an arithmetic model of the hit test, addressing and frame sequencing.
module tb_sprite_animator;

  localparam int SPR_W = 64;
  localparam int SPR_H = 96;
  localparam int NUM_FRAMES = 6;
  localparam int HOLD = 4;

  logic        vga_clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  DrawX = '0, DrawY = '0, pos_x = '0, pos_y = '0;
  logic        blank = 1'b0, flip = 1'b0, frame_tick = 1'b0, anim_start = 1'b0, loop_mode = 1'b1;
  logic [15:0] rom_address;
  logic [3:0]  rom_q = '0;
  logic [3:0]  pix_idx;
  logic        pix_on;
  logic [2:0]  cur_frame;
  logic        anim_done;
  logic [1:0]  anim_state;

  int n_checks = 0;
  int n_fail = 0;
  logic       rom_force_en = 1'b0;
  logic [3:0] rom_force_val = '0;
  logic [15:0] exp_addr_q[$];
  logic [3:0]  exp_q[$];
  logic        exp_on_q[$];

  always #5 vga_clk = ~vga_clk;

  sprite_animator dut (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .pos_x(pos_x), .pos_y(pos_y), .flip(flip), .frame_tick(frame_tick),
    .anim_start(anim_start), .loop_mode(loop_mode), .rom_address(rom_address),
    .rom_q(rom_q), .pix_idx(pix_idx), .pix_on(pix_on), .cur_frame(cur_frame),
    .anim_done(anim_done), .anim_state(anim_state)
  );

  function automatic logic [3:0] rom_fn(int a);
    return 4'((a * 37) ^ (a >> 3));
  endfunction

  // One-cycle-latency ROM
  always @(posedge vga_clk) rom_q <= rom_force_en ? rom_force_val : rom_fn(int'(rom_address));

  function automatic bit ref_hit(int dx, int dy, int px, int py);
    return dx >= px && dx < px + SPR_W && dy >= py && dy < py + SPR_H;
  endfunction

  function automatic int ref_addr(int frame, int dx, int dy, int px, int py, bit fl);
    int c;
    if (!ref_hit(dx, dy, px, py)) return 0;
    c = dx - px;
    return frame * SPR_W * SPR_H + (dy - py) * SPR_W + (fl ? SPR_W - 1 - c : c);
  endfunction

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic start();
    anim_start = 1'b1;
    step();
    anim_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; blank = 1'b1; pos_x = 10'd100; pos_y = 10'd50; DrawX = 10'd120; DrawY = 10'd60;
    repeat (3) step();
    n_checks += 6;
    if (rom_address !== 16'd0) begin n_fail++; $display("FAIL reset_addr got=%0d exp=0", rom_address); end
    if (pix_idx !== 4'd0) begin n_fail++; $display("FAIL reset_idx got=%0d exp=0", pix_idx); end
    if (pix_on !== 1'b0) begin n_fail++; $display("FAIL reset_on got=%0b exp=0", pix_on); end
    if (cur_frame !== 3'd0) begin n_fail++; $display("FAIL reset_frame got=%0d exp=0", cur_frame); end
    if (anim_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%0b exp=0", anim_done); end
    if (anim_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", anim_state); end
  endtask

  task automatic test_latency();
    DrawX = 10'd100; DrawY = 10'd50; flip = 1'b0; blank = 1'b1;
    rom_force_en = 1'b1; rom_force_val = 4'd9;
    reset = 1'b0;
    step();
    n_checks++;
    if (rom_address !== 16'd0) begin n_fail++; $display("FAIL lat_addr got=%0d exp=0", rom_address); end
    step();
    n_checks++;
    if (pix_on !== 1'b0) begin n_fail++; $display("FAIL lat_early_on got=%0b exp=0", pix_on); end
    step();
    n_checks += 2;
    if (pix_on !== 1'b1) begin n_fail++; $display("FAIL lat_on got=%0b exp=1", pix_on); end
    if (pix_idx !== 4'd9) begin n_fail++; $display("FAIL lat_idx got=%0d exp=9", pix_idx); end
    rom_force_val = 4'd0;
    repeat (2) step();
    n_checks += 2;
    if (pix_on !== 1'b0) begin n_fail++; $display("FAIL transp_on got=%0b exp=0", pix_on); end
    if (pix_idx !== 4'd0) begin n_fail++; $display("FAIL transp_idx got=%0d exp=0", pix_idx); end
  endtask

  task automatic test_flip();
    rom_force_en = 1'b0;
    DrawX = 10'd100; DrawY = 10'd51; flip = 1'b1;
    step();
    n_checks++;
    if (rom_address !== 16'd127) begin n_fail++; $display("FAIL flip1_addr got=%0d exp=127", rom_address); end
    flip = 1'b0;
    step();
    n_checks++;
    if (rom_address !== 16'd64) begin n_fail++; $display("FAIL flip0_addr got=%0d exp=64", rom_address); end
    DrawX = 10'd164;
    step();
    n_checks++;
    if (rom_address !== 16'd0) begin n_fail++; $display("FAIL outside_addr got=%0d exp=0", rom_address); end
    repeat (2) step();
    n_checks++;
    if (pix_on !== 1'b0) begin n_fail++; $display("FAIL outside_on got=%0b exp=0", pix_on); end
  endtask

  task automatic test_blank();
    DrawX = 10'd100; DrawY = 10'd50; rom_force_en = 1'b1; rom_force_val = 4'd5; blank = 1'b0;
    repeat (3) step();
    n_checks += 2;
    if (pix_on !== 1'b0) begin n_fail++; $display("FAIL blank0_on got=%0b exp=0", pix_on); end
    if (pix_idx !== 4'd0) begin n_fail++; $display("FAIL blank0_idx got=%0d exp=0", pix_idx); end
    blank = 1'b1;
    repeat (3) step();
    n_checks += 2;
    if (pix_on !== 1'b1) begin n_fail++; $display("FAIL blank1_on got=%0b exp=1", pix_on); end
    if (pix_idx !== 4'd5) begin n_fail++; $display("FAIL blank1_idx got=%0d exp=5", pix_idx); end
    rom_force_en = 1'b0;
  endtask

  task automatic test_random_pixels(int frame, int n);
    int px, py, dx, dy, a;
    bit fl, bl, h;
    logic [3:0] v;
    rom_force_en = 1'b0;
    exp_addr_q.delete(); exp_q.delete(); exp_on_q.delete();
    for (int t = 0; t < n + 3; t++) begin
      step();
      if (exp_addr_q.size() == 1) begin
        logic [15:0] ea;
        ea = exp_addr_q.pop_front();
        n_checks++;
        if (rom_address !== ea) begin n_fail++; $display("FAIL rnd_addr t=%0d got=%0d exp=%0d", t, rom_address, ea); end
      end
      if (exp_on_q.size() == 3) begin
        logic eo;
        logic [3:0] ei;
        eo = exp_on_q.pop_front();
        ei = exp_q.pop_front();
        n_checks += 2;
        if (pix_on !== eo) begin n_fail++; $display("FAIL rnd_on t=%0d got=%0b exp=%0b", t, pix_on, eo); end
        if (pix_idx !== ei) begin n_fail++; $display("FAIL rnd_idx t=%0d got=%0d exp=%0d", t, pix_idx, ei); end
      end
      px = ($urandom_range(0, 3) == 0) ? int'($urandom_range(960, 1023)) : int'($urandom_range(0, 1023));
      py = ($urandom_range(0, 3) == 0) ? int'($urandom_range(960, 1023)) : int'($urandom_range(0, 1023));
      dx = (px + int'($urandom_range(0, 75)) - 6) & 1023;
      dy = (py + int'($urandom_range(0, 107)) - 6) & 1023;
      fl = 1'($urandom_range(0, 1));
      bl = ($urandom_range(0, 3) != 0);
      pos_x = 10'(px); pos_y = 10'(py); DrawX = 10'(dx); DrawY = 10'(dy); flip = fl; blank = bl;
      h = ref_hit(dx, dy, px, py);
      a = ref_addr(frame, dx, dy, px, py, fl);
      v = rom_fn(a);
      exp_addr_q.push_back(16'(a));
      exp_on_q.push_back(h && bl && v != 4'd0);
      exp_q.push_back((h && bl && v != 4'd0) ? v : 4'd0);
    end
  endtask

  task automatic test_loop();
    int ef;
    loop_mode = 1'b1; blank = 1'b1; flip = 1'b0;
    start();
    n_checks += 2;
    if (cur_frame !== 3'd0) begin n_fail++; $display("FAIL loop_start_frame got=%0d exp=0", cur_frame); end
    if (anim_state !== 2'd1) begin n_fail++; $display("FAIL loop_start_state got=%0d exp=1", anim_state); end
    for (int k = 1; k <= 24; k++) begin
      tick();
      ef = (k / HOLD) % NUM_FRAMES;
      n_checks += 2;
      if (cur_frame !== 3'(ef)) begin n_fail++; $display("FAIL loop_frame k=%0d got=%0d exp=%0d", k, cur_frame, ef); end
      if (anim_done !== 1'b0) begin n_fail++; $display("FAIL loop_done k=%0d got=%0b exp=0", k, anim_done); end
      step();
      n_checks++;
      if (anim_done !== 1'b0) begin n_fail++; $display("FAIL loop_done2 k=%0d got=%0b exp=0", k, anim_done); end
      if (k == 8) begin
        pos_x = 10'd300; pos_y = 10'd200; DrawX = 10'd300; DrawY = 10'd200;
        step();
        n_checks++;
        if (rom_address !== 16'd12288) begin n_fail++; $display("FAIL frame2_addr got=%0d exp=12288", rom_address); end
        test_random_pixels(2, 40);
      end
    end
  endtask

  task automatic test_oneshot();
    int ef;
    bit ed;
    loop_mode = 1'b0;
    start();
    for (int k = 1; k <= 28; k++) begin
      tick();
      ef = (k / HOLD > NUM_FRAMES - 1) ? NUM_FRAMES - 1 : k / HOLD;
      ed = (k == HOLD * NUM_FRAMES);
      n_checks += 2;
      if (cur_frame !== 3'(ef)) begin n_fail++; $display("FAIL os_frame k=%0d got=%0d exp=%0d", k, cur_frame, ef); end
      if (anim_done !== ed) begin n_fail++; $display("FAIL os_done k=%0d got=%0b exp=%0b", k, anim_done, ed); end
      step();
      n_checks++;
      if (anim_done !== 1'b0) begin n_fail++; $display("FAIL os_done_pulse k=%0d got=%0b exp=0", k, anim_done); end
    end
    n_checks++;
    if (anim_state !== 2'd2) begin n_fail++; $display("FAIL os_state got=%0d exp=2", anim_state); end
    start();
    n_checks += 2;
    if (cur_frame !== 3'd0) begin n_fail++; $display("FAIL os_restart_frame got=%0d exp=0", cur_frame); end
    if (anim_state !== 2'd1) begin n_fail++; $display("FAIL os_restart_state got=%0d exp=1", anim_state); end
  endtask

  task automatic test_collision();
    loop_mode = 1'b1;
    start();
    repeat (5) tick();
    n_checks++;
    if (cur_frame !== 3'd1) begin n_fail++; $display("FAIL col_pre_frame got=%0d exp=1", cur_frame); end
    anim_start = 1'b1; frame_tick = 1'b1;
    step();
    anim_start = 1'b0; frame_tick = 1'b0;
    n_checks += 2;
    if (cur_frame !== 3'd0) begin n_fail++; $display("FAIL col_frame got=%0d exp=0", cur_frame); end
    if (anim_done !== 1'b0) begin n_fail++; $display("FAIL col_done got=%0b exp=0", anim_done); end
    repeat (3) tick();
    n_checks++;
    if (cur_frame !== 3'd0) begin n_fail++; $display("FAIL col_hold3 got=%0d exp=0", cur_frame); end
    tick();
    n_checks++;
    if (cur_frame !== 3'd1) begin n_fail++; $display("FAIL col_hold4 got=%0d exp=1", cur_frame); end
  endtask

  task automatic test_reset_midplay();
    pos_x = 10'd100; pos_y = 10'd50; DrawX = 10'd110; DrawY = 10'd60; blank = 1'b1;
    rom_force_en = 1'b1; rom_force_val = 4'd7;
    repeat (4) step();
    n_checks++;
    if (pix_on !== 1'b1) begin n_fail++; $display("FAIL mid_on got=%0b exp=1", pix_on); end
    reset = 1'b1; blank = 1'b0;
    step();
    reset = 1'b0;
    n_checks += 6;
    if (rom_address !== 16'd0) begin n_fail++; $display("FAIL mid_rst_addr got=%0d exp=0", rom_address); end
    if (pix_idx !== 4'd0) begin n_fail++; $display("FAIL mid_rst_idx got=%0d exp=0", pix_idx); end
    if (pix_on !== 1'b0) begin n_fail++; $display("FAIL mid_rst_on got=%0b exp=0", pix_on); end
    if (cur_frame !== 3'd0) begin n_fail++; $display("FAIL mid_rst_frame got=%0d exp=0", cur_frame); end
    if (anim_done !== 1'b0) begin n_fail++; $display("FAIL mid_rst_done got=%0b exp=0", anim_done); end
    if (anim_state !== 2'd0) begin n_fail++; $display("FAIL mid_rst_state got=%0d exp=0", anim_state); end
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (pix_on !== 1'b0) begin n_fail++; $display("FAIL stale_on i=%0d got=%0b exp=0", i, pix_on); end
    end
    repeat (HOLD) tick();
    n_checks++;
    if (cur_frame !== 3'd0) begin n_fail++; $display("FAIL idle_tick_frame got=%0d exp=0", cur_frame); end
    rom_force_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_flip();
    test_blank();
    test_random_pixels(0, 200);
    test_loop();
    test_oneshot();
    test_collision();
    test_reset_midplay();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_animator.md
Name: sprite_animator

Overview:
Parametrised sprite pixel engine for character animation (stand, walk, punch loops).
- Per pixel: decides whether the current beam position (DrawX, DrawY) lies inside a positioned, optionally mirrored sprite, and addresses a synchronous multi-frame sprite ROM.
- Emits a palette index plus a pixel-on flag after the fixed pipeline latency; a transparent colour key is applied.
- Sequences animation frames on per-video-frame ticks in loop or one-shot mode.
- Sits between the VGA controller and the palette/compositor stage.

Parameters:
SPR_W, 64, sprite width in pixels
SPR_H, 96, sprite height in pixels
NUM_FRAMES, 6, animation frames stored back-to-back in ROM, frame f at base f*SPR_W*SPR_H
HOLD, 4, frame_tick pulses each animation frame is displayed (>=1)
IDX_W, 4, palette index width
ADDR_W, 16, ROM address width; must satisfy NUM_FRAMES*SPR_W*SPR_H <= 2^ADDR_W
COORD_W, 10, DrawX/DrawY/position width
TRANSP_IDX, 0, palette index treated as transparent
ROM_LAT, 1, ROM read latency in vga_clk cycles (>=1)

Ports:
vga_clk  input  1  sole clock; all state updates on posedge
reset  input  1  synchronous, active-high
DrawX  input  COORD_W  current pixel column
DrawY  input  COORD_W  current pixel row
blank  input  1  1 = active video (display enabled)
pos_x  input  COORD_W  sprite top-left column
pos_y  input  COORD_W  sprite top-left row
flip  input  1  1 = mirror horizontally (facing left)
frame_tick  input  1  one-cycle pulse per video frame (vsync)
anim_start  input  1  one-cycle pulse: restart animation at frame 0
loop_mode  input  1  1 = loop, 0 = one-shot
rom_address  output  ADDR_W  registered ROM address
rom_q  input  IDX_W  ROM data, valid ROM_LAT cycles after rom_address changes
pix_idx  output  IDX_W  palette index (0 when pix_on=0)
pix_on  output  1  sprite pixel visible and opaque
cur_frame  output  clog2(NUM_FRAMES)  current animation frame
anim_done  output  1  one-cycle pulse when one-shot animation completes

Behaviour:
- Reset (synchronous, active-high), takes priority over all inputs:
  - Outputs: rom_address=0, pix_idx=0, pix_on=0, cur_frame=0, anim_done=0.
  - Internal: state=IDLE, hold count=0, all pipeline valid/hit/blank delay bits cleared. Reset mid-animation or mid-line discards in-flight pixels.
- Hit test (COORD_W+1-bit arithmetic, no wrap):
  - hit = DrawX>=pos_x && DrawX<pos_x+SPR_W && DrawY>=pos_y && DrawY<pos_y+SPR_H.
  - col = DrawX-pos_x; row = DrawY-pos_y.
  - Effective column ecol = flip ? SPR_W-1-col : col.
- Address: rom_address <= hit ? cur_frame*SPR_W*SPR_H + row*SPR_W + ecol : 0, registered at edge 1.
- Pipeline: hit and blank are delayed ROM_LAT+1 stages to align with rom_q. At edge ROM_LAT+2:
  - pix_on <= hit_d & blank_d & (rom_q != TRANSP_IDX).
  - pix_idx <= pix_on_next ? rom_q : 0.
  - Total latency from DrawX/DrawY/blank sample to pix_idx/pix_on = ROM_LAT+2 cycles (3 by default). Throughput is one pixel per clock, with no stalls.
- Animation FSM, states IDLE, PLAY, DONE:
  - IDLE: cur_frame=0, frame_tick ignored; anim_start -> PLAY.
  - PLAY: on frame_tick, hold count increments.
  - When hold count==HOLD-1 and frame_tick arrives: hold count=0 and the frame advances.
    - Not last frame -> cur_frame+1.
    - Last frame, loop_mode=1 -> cur_frame=0, stay PLAY.
    - Last frame, loop_mode=0 -> cur_frame stays NUM_FRAMES-1, state DONE, anim_done=1 for exactly that one cycle.
  - DONE: holds last frame, frame_tick ignored; anim_start -> PLAY.
  - anim_start in any state: cur_frame=0, hold count=0, state PLAY. anim_start wins over a same-cycle frame_tick (tick ignored, no anim_done).
  - loop_mode is sampled at the wrap decision, so changing it mid-animation takes effect at the next wrap.
- A cur_frame change affects addresses computed from the next cycle on; frame_tick is vsync-aligned, so no mid-frame tearing.
- Partially off-screen sprites (pos_x+SPR_W beyond screen width) are clipped naturally; no wrap to column 0.

Test Plan:
- Reset/latency: SPR_W=64, SPR_H=96, ROM_LAT=1, pos=(100,50), flip=0, blank=1, DrawX=100, DrawY=50 -> rom_address=0 after 1 clock; pix_on/pix_idx reflect rom_q(0) 3 clocks after sample; rom_q=TRANSP_IDX -> pix_on=0, pix_idx=0.
- Flip: DrawX=100, DrawY=51, flip=1 -> rom_address=64+63=127; flip=0 -> 64; DrawX=164 (out of range) -> rom_address=0, pix_on=0 three cycles later.
- Blank gating: in-sprite pixel with opaque rom_q=5 and blank=0 -> pix_on=0, pix_idx=0; blank=1 -> pix_idx=5, pix_on=1.
- Loop animation: HOLD=4, NUM_FRAMES=6, loop_mode=1, anim_start, then 24 frame_ticks -> cur_frame advances every 4 ticks 0..5 and returns to 0 at tick 24; anim_done never asserted; frame 2 pixel (0,0) -> rom_address=12288.
- One-shot: loop_mode=0, anim_start, 24 ticks -> anim_done high exactly one cycle at tick 24, cur_frame stays 5; further ticks leave frame 5; anim_start -> cur_frame=0, PLAY.
- Collisions: anim_start coincident with frame_tick -> cur_frame=0, hold count=0 (tick ignored); reset asserted mid-PLAY with pixels in flight -> next cycle all outputs 0, state IDLE, no stale pix_on emerges.
